// File: rtl/addr1_queue_ctrl_if.sv
// ---------------------------------------------------------------------------
// addr1_queue_ctrl_if
// Bundles every non-clock signal of addr1_queue_ctrl: the decoupled enq/deq
// handshake, flush, occupancy count and the W0/R0 ports of the 1R1W SRAM
// macro owned by the controller.
//   slave  : the queue controller (accepts enq, produces deq, drives macro)
//   master : producer/consumer plus the macro read-data return
// ---------------------------------------------------------------------------
interface addr1_queue_ctrl_if #(
    parameter int WIDTH = 17,
    parameter int AW    = 3
);
    logic             io_flush;
    logic             io_enq_valid;
    logic             io_enq_ready;
    logic [WIDTH-1:0] io_enq_bits;
    logic             io_deq_valid;
    logic             io_deq_ready;
    logic [WIDTH-1:0] io_deq_bits;
    logic [AW+1:0]    io_count;
    logic [AW-1:0]    W0_addr;
    logic             W0_en;
    logic [WIDTH-1:0] W0_data;
    logic [AW-1:0]    R0_addr;
    logic             R0_en;
    logic [WIDTH-1:0] R0_data;

    modport slave (
        input  io_flush, io_enq_valid, io_enq_bits, io_deq_ready, R0_data,
        output io_enq_ready, io_deq_valid, io_deq_bits, io_count,
               W0_addr, W0_en, W0_data, R0_addr, R0_en
    );

    modport master (
        output io_flush, io_enq_valid, io_enq_bits, io_deq_ready, R0_data,
        input  io_enq_ready, io_deq_valid, io_deq_bits, io_count,
               W0_addr, W0_en, W0_data, R0_addr, R0_en
    );
endinterface

// File: rtl/addr1_queue_ctrl.sv
// ---------------------------------------------------------------------------
// addr1_queue_ctrl
// Ready/valid FIFO controller around a DEPTH x WIDTH 1R1W sync-read SRAM.
// The macro returns read data one cycle after R0_en, so a 2-entry output
// buffer (head/tail) hides that latency and deq sustains one word per cycle.
// Total capacity is DEPTH+2 words.
// Ports:
//   clock   - sole clock (also clocks the macro externally)
//   reset_n - asynchronous active-low reset
//   bus     - slave side of addr1_queue_ctrl_if: enq/deq handshake, flush,
//             io_count, W0_* / R0_* macro ports, R0_data return
// ---------------------------------------------------------------------------
module addr1_queue_ctrl #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 17,
    parameter int AW    = 3
) (
    input  logic               clock,
    input  logic               reset_n,
    addr1_queue_ctrl_if.slave  bus
);

    localparam logic [AW:0] RAM_FULL = (AW+1)'(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      ram_cnt_q, ram_cnt_d;
    logic             inflight_q, inflight_d;
    logic [1:0]       buf_cnt_q, buf_cnt_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;

    logic             enq_ready_s;
    logic             enq_fire_s;
    logic             deq_fire_s;
    logic             issue_s;
    logic [1:0]       occ_after_s;
    logic [1:0]       buf_cnt_pop_s;
    logic [AW+1:0]    count_s;

    // Handshake decode and read-issue decision.
    always_comb begin
        enq_ready_s = (ram_cnt_q != RAM_FULL) && !bus.io_flush;
        enq_fire_s  = bus.io_enq_valid && enq_ready_s;
        deq_fire_s  = (buf_cnt_q != 2'd0) && bus.io_deq_ready && !bus.io_flush;
        // buf_cnt + inflight never exceeds 2, and deq_fire implies buf_cnt>0,
        // so this 2-bit sum cannot wrap.
        occ_after_s = buf_cnt_q + {1'b0, inflight_q} - {1'b0, deq_fire_s};
        issue_s     = (ram_cnt_q != {(AW+1){1'b0}}) && !bus.io_flush
                      && (occ_after_s < 2'd2);
        count_s     = {1'b0, ram_cnt_q} + {{(AW+1){1'b0}}, inflight_q}
                      + {{AW{1'b0}}, buf_cnt_q};
    end

    // Next-state for pointers, SRAM count, read tracking and output buffer.
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        ram_cnt_d     = ram_cnt_q;
        inflight_d    = issue_s;
        head_d        = head_q;
        tail_d        = tail_q;
        buf_cnt_pop_s = buf_cnt_q;
        buf_cnt_d     = buf_cnt_q;

        if (enq_fire_s) begin
            wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (issue_s) begin
            rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({enq_fire_s, issue_s})
            2'b10:   ram_cnt_d = ram_cnt_q + {{AW{1'b0}}, 1'b1};
            2'b01:   ram_cnt_d = ram_cnt_q - {{AW{1'b0}}, 1'b1};
            default: ram_cnt_d = ram_cnt_q;
        endcase

        // Pop first so the returning word lands in the slot the pop leaves.
        if (deq_fire_s) begin
            head_d        = tail_q;
            buf_cnt_pop_s = buf_cnt_q - 2'd1;
        end else begin
            buf_cnt_pop_s = buf_cnt_q;
        end

        if (inflight_q) begin
            if (buf_cnt_pop_s == 2'd0) begin
                head_d = bus.R0_data;
            end else begin
                tail_d = bus.R0_data;
            end
            buf_cnt_d = buf_cnt_pop_s + 2'd1;
        end else begin
            buf_cnt_d = buf_cnt_pop_s;
        end

        // Flush drops everything, including a read return arriving now.
        if (bus.io_flush) begin
            wr_ptr_d   = {AW{1'b0}};
            rd_ptr_d   = {AW{1'b0}};
            ram_cnt_d  = {(AW+1){1'b0}};
            inflight_d = 1'b0;
            buf_cnt_d  = 2'd0;
        end else begin
            buf_cnt_d  = buf_cnt_d;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            ram_cnt_q  <= {(AW+1){1'b0}};
            inflight_q <= 1'b0;
            buf_cnt_q  <= 2'd0;
            head_q     <= {WIDTH{1'b0}};
            tail_q     <= {WIDTH{1'b0}};
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ram_cnt_q  <= ram_cnt_d;
            inflight_q <= inflight_d;
            buf_cnt_q  <= buf_cnt_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    // Macro strobes are gated by reset_n so they drop without a clock edge.
    always_comb begin
        bus.io_enq_ready = enq_ready_s;
        bus.io_deq_valid = (buf_cnt_q != 2'd0);
        bus.io_deq_bits  = head_q;
        bus.io_count     = count_s;
        bus.W0_en        = enq_fire_s && reset_n;
        bus.W0_addr      = wr_ptr_q;
        bus.W0_data      = bus.io_enq_bits;
        bus.R0_en        = issue_s && reset_n;
        bus.R0_addr      = rd_ptr_q;
    end

endmodule
